param_priority_arbiter: RTL and testbench

N-requester arbiter built on a registered FSM, generalising the team's 4-input fixed-priority arbiter FSM. Two arbitration modes, selected by parameter:
- fixed priority, lowest index wins;
- round-robin.
An owner keeps its grant while its request stays high, with optional preemption by higher-priority requesters and an optional maximum-hold timeout. It sits between N bus masters and one shared resource; its grant outputs are registered.

---
 rtl/param_priority_arbiter.sv | 130 +++++++++++++
 tb/tb_param_priority_arbiter.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/param_priority_arbiter.sv
// N-requester arbiter: fixed-priority or round-robin selection, registered one-hot grant,
// optional preemption and max-hold timeout, with a mandatory idle cycle between owners.
module param_priority_arbiter #(
  parameter  int N        = 4,
  parameter  int MODE     = 0,
  parameter  int PREEMPT  = 1,
  parameter  int MAX_HOLD = 0,
  localparam int IDW      = (N > 2) ? $clog2(N) : 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req,
  output logic [N-1:0]   grnt,
  output logic [IDW-1:0] grnt_id,
  output logic           grnt_valid,
  output logic           hold_expired
);

  typedef enum logic {IDLE, GRANT} state_e;

  localparam logic [7:0] HOLD_LIM = 8'(MAX_HOLD);

  state_e         state_q, state_d;
  logic [N-1:0]   grnt_q, grnt_d;
  logic [IDW-1:0] id_q, id_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [7:0]     cnt_q, cnt_d;
  logic           hexp_q, hexp_d;

  logic           own_drop;
  logic           preempt_hit;
  logic           timeout;
  logic [IDW-1:0] win;

  function automatic logic [IDW-1:0] pick_fixed(input logic [N-1:0] r);
    pick_fixed = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (r[i]) pick_fixed = IDW'(i);
    end
  endfunction

  // Search upward from the pointer, wrapping modulo N (N need not be a power of two).
  function automatic logic [IDW-1:0] pick_rr(input logic [N-1:0] r, input logic [IDW-1:0] p);
    logic found;
    int   idx;
    pick_rr = '0;
    found   = 1'b0;
    for (int i = 0; i < N; i++) begin
      idx = int'(p) + i;
      if (idx >= N) idx = idx - N;
      if (!found && r[idx]) begin
        pick_rr = IDW'(idx);
        found   = 1'b1;
      end
    end
  endfunction

  always_comb begin
    state_d     = state_q;
    grnt_d      = grnt_q;
    id_d        = id_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    hexp_d      = 1'b0;
    own_drop    = 1'b0;
    preempt_hit = 1'b0;
    timeout     = 1'b0;
    win         = '0;
    case (state_q)
      IDLE: begin
        if (|req) begin
          win     = (MODE == 1) ? pick_rr(req, ptr_q) : pick_fixed(req);
          state_d = GRANT;
          grnt_d  = N'(1) << win;
          id_d    = win;
          cnt_d   = 8'd1;
        end else begin
          grnt_d = '0;
          id_d   = '0;
          cnt_d  = '0;
        end
      end
      GRANT: begin
        own_drop = !req[id_q];
        if (MODE == 0 && PREEMPT != 0) begin
          for (int j = 0; j < N; j++) begin
            if (j < int'(id_q) && req[j]) preempt_hit = 1'b1;
          end
        end
        timeout = (MAX_HOLD != 0) && (cnt_q == HOLD_LIM);
        if (own_drop || preempt_hit || timeout) begin
          // Release always passes through IDLE, giving the dead cycle.
          state_d = IDLE;
          grnt_d  = '0;
          id_d    = '0;
          cnt_d   = '0;
          hexp_d  = timeout;
          ptr_d   = (id_q == IDW'(N - 1)) ? '0 : id_q + IDW'(1);
        end else if (cnt_q != 8'hFF) begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      grnt_q  <= '0;
      id_q    <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      hexp_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      grnt_q  <= grnt_d;
      id_q    <= id_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      hexp_q  <= hexp_d;
    end
  end

  assign grnt         = grnt_q;
  assign grnt_id      = id_q;
  assign grnt_valid   = (state_q == GRANT);
  assign hold_expired = hexp_q;

endmodule

// File: tb/tb_param_priority_arbiter.sv
// Directed bench for param_priority_arbiter: fixed priority with and without preemption,
// round-robin at N=4 and N=3, max-hold timeout, and asynchronous reset mid-grant.
module tb_param_priority_arbiter;

  logic clk;
  logic rst;

  logic [3:0] req_fp, grnt_fp;  logic [1:0] id_fp;  logic vld_fp, hx_fp;
  logic [3:0] req_np, grnt_np;  logic [1:0] id_np;  logic vld_np, hx_np;
  logic [3:0] req_rr, grnt_rr;  logic [1:0] id_rr;  logic vld_rr, hx_rr;
  logic [3:0] req_to, grnt_to;  logic [1:0] id_to;  logic vld_to, hx_to;
  logic [2:0] req_r3, grnt_r3;  logic [1:0] id_r3;  logic vld_r3, hx_r3;

  int n_chk  = 0;
  int n_pass = 0;

  param_priority_arbiter #(.N(4), .MODE(0), .PREEMPT(1), .MAX_HOLD(0)) u_fp (
    .clk(clk), .rst(rst), .req(req_fp), .grnt(grnt_fp), .grnt_id(id_fp),
    .grnt_valid(vld_fp), .hold_expired(hx_fp));

  param_priority_arbiter #(.N(4), .MODE(0), .PREEMPT(0), .MAX_HOLD(0)) u_np (
    .clk(clk), .rst(rst), .req(req_np), .grnt(grnt_np), .grnt_id(id_np),
    .grnt_valid(vld_np), .hold_expired(hx_np));

  param_priority_arbiter #(.N(4), .MODE(1), .PREEMPT(1), .MAX_HOLD(0)) u_rr (
    .clk(clk), .rst(rst), .req(req_rr), .grnt(grnt_rr), .grnt_id(id_rr),
    .grnt_valid(vld_rr), .hold_expired(hx_rr));

  param_priority_arbiter #(.N(4), .MODE(1), .PREEMPT(1), .MAX_HOLD(3)) u_to (
    .clk(clk), .rst(rst), .req(req_to), .grnt(grnt_to), .grnt_id(id_to),
    .grnt_valid(vld_to), .hold_expired(hx_to));

  param_priority_arbiter #(.N(3), .MODE(1), .PREEMPT(1), .MAX_HOLD(0)) u_r3 (
    .clk(clk), .rst(rst), .req(req_r3), .grnt(grnt_r3), .grnt_id(id_r3),
    .grnt_valid(vld_r3), .hold_expired(hx_r3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [3:0] e4;
  logic [2:0] e3;

  initial begin
    rst    = 1'b0;
    req_fp = '0; req_np = '0; req_rr = '0; req_to = '0; req_r3 = '0;
    #12;
    check("rst_grnt_fp", grnt_fp, 4'b0000);
    check("rst_grnt_to", grnt_to, 4'b0000);
    check("rst_vld_rr", vld_rr, 1'b0);
    rst = 1'b1;

    for (int i = 0; i < 5; i++) begin
      tick();
      check("idle_grnt", grnt_fp, 4'b0000);
      check("idle_vld", vld_fp, 1'b0);
      check("idle_hx", hx_fp, 1'b0);
      check("idle_id", id_fp, 2'd0);
    end

    // Fixed priority: 1100 -> owner 2 holds, then hands to 3 after a dead cycle.
    req_fp = 4'b1100;
    tick();
    check("fp_grnt", grnt_fp, 4'b0100);
    check("fp_id", id_fp, 2'd2);
    check("fp_vld", vld_fp, 1'b1);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("fp_hold", grnt_fp, 4'b0100);
    end
    req_fp = 4'b1000;
    tick();
    check("fp_dead_grnt", grnt_fp, 4'b0000);
    check("fp_dead_vld", vld_fp, 1'b0);
    check("fp_dead_hx", hx_fp, 1'b0);
    tick();
    check("fp_next_grnt", grnt_fp, 4'b1000);
    check("fp_next_id", id_fp, 2'd3);

    // Preemption: req[0] revokes owner 3.
    req_fp = 4'b1001;
    tick();
    check("pre_dead", grnt_fp, 4'b0000);
    check("pre_hx", hx_fp, 1'b0);
    tick();
    check("pre_grnt", grnt_fp, 4'b0001);
    check("pre_id", id_fp, 2'd0);
    req_fp = '0;
    tick();
    tick();

    // No preemption: owner 3 keeps the grant until req[3] drops.
    req_np = 4'b1000;
    tick();
    check("np_grnt", grnt_np, 4'b1000);
    req_np = 4'b1001;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("np_keep", grnt_np, 4'b1000);
    end
    req_np = 4'b0001;
    tick();
    check("np_dead", grnt_np, 4'b0000);
    tick();
    check("np_grnt0", grnt_np, 4'b0001);
    check("np_id0", id_np, 2'd0);
    req_np = '0;
    tick();
    tick();

    // Round-robin N=4 with all requesting.
    req_rr = 4'hF;
    tick();
    for (int i = 0; i < 4; i++) begin
      e4 = 4'(1 << i);
      check("rr_grnt", grnt_rr, e4);
      check("rr_id", id_rr, i);
      req_rr = 4'hF & ~e4;
      tick();
      check("rr_dead", grnt_rr, 4'b0000);
      req_rr = 4'hF;
      tick();
    end
    check("rr_wrap", grnt_rr, 4'b0001);
    req_rr = '0;
    tick();
    check("rr_rel", grnt_rr, 4'b0000);
    tick();

    // Round-robin N=3: wrap modulo 3, id never above 2.
    req_r3 = 3'b111;
    tick();
    for (int i = 0; i < 4; i++) begin
      e3 = 3'(1 << (i % 3));
      check("r3_grnt", grnt_r3, e3);
      check("r3_id", id_r3, i % 3);
      req_r3 = 3'b111 & ~e3;
      tick();
      check("r3_dead", grnt_r3, 3'b000);
      req_r3 = 3'b111;
      tick();
    end
    req_r3 = '0;
    tick();
    tick();

    // MAX_HOLD=3 timeout in round-robin.
    req_to = 4'b0011;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("to_hold", grnt_to, 4'b0001);
      check("to_hx_lo", hx_to, 1'b0);
    end
    tick();
    check("to_dead", grnt_to, 4'b0000);
    check("to_hx", hx_to, 1'b1);
    check("to_dead_vld", vld_to, 1'b0);
    tick();
    check("to_next", grnt_to, 4'b0010);
    check("to_next_id", id_to, 2'd1);
    check("to_hx_clr", hx_to, 1'b0);

    // Asynchronous reset mid-grant, no clock edge in between.
    #2;
    rst = 1'b0;
    #1;
    check("ar_grnt", grnt_to, 4'b0000);
    check("ar_vld", vld_to, 1'b0);
    check("ar_id", id_to, 2'd0);
    req_to = 4'b0010;
    req_rr = 4'hF;
    #2;
    rst = 1'b1;
    tick();
    check("ar_regrant", grnt_to, 4'b0010);
    check("ar_rr_ptr0", grnt_rr, 4'b0001);
    check("ar_rr_id", id_rr, 2'd0);

    req_to = '0;
    req_rr = '0;
    tick();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
